// File: rtl/usb_pkg.sv
// Shared USB block definitions: arbiter state encoding and the rotating
// first-set-bit search that both the OUT-side and IN-side arbiters use.
package usb_pkg;

  localparam int MAX_EPS  = 16;
  localparam int EP_IDX_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STREAM = 2'd1,
    ARB_DRAIN  = 2'd2
  } arb_state_e;

  // Index of the first set bit of req[n-1:0] at or after ptr, wrapping at n.
  // Returns 0 when nothing is set; callers test the request vector themselves.
  function automatic logic [EP_IDX_W-1:0] first_set_from(
    input logic [MAX_EPS-1:0]  req,
    input logic [EP_IDX_W-1:0] ptr,
    input int unsigned         n
  );
    logic [EP_IDX_W-1:0] sel;
    logic [EP_IDX_W-1:0] idx4;
    logic                found;
    int unsigned         idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_EPS; i++) begin
      idx  = (32'(ptr) + i) % n;
      idx4 = EP_IDX_W'(idx);
      if (!found && (i < n) && req[idx4]) begin
        sel   = idx4;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/usb_skid_fifo2.sv
// Two-entry valid/ready FIFO. The producer side has no ready: the caller
// bounds its pushes with the exported occupancy count.
module usb_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (in_valid) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(in_valid) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(in_valid && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/usb_out_ep_arbiter.sv
// OUT endpoint read arbiter: grants one endpoint per packet and turns the
// engine's registered read port into a tagged valid/ready byte stream.
// Build option USB_OUT_ARB_FIXED_PRIO_EN: lowest-numbered endpoint always wins.
module usb_out_ep_arbiter
  import usb_pkg::*;
#(
  parameter int NUM_OUT_EPS = 2,
  parameter int EP_NUM_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
  output logic [NUM_OUT_EPS-1:0] out_ep_data_get,
  input  logic [7:0]             out_ep_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [7:0]             m_data,
  output logic [EP_NUM_W-1:0]    m_ep,
  output logic                   m_last,
  output logic                   pkt_abort,
  output logic                   busy
);

  localparam int FW = 8 + EP_NUM_W + 1;

  arb_state_e          state_q, state_d;
  logic [EP_IDX_W-1:0] gnt_ep_q, gnt_ep_d;
  logic                inflight_q, inflight_d;
  logic                pkt_abort_q, pkt_abort_d;
  logic [EP_IDX_W-1:0] start_ptr, next_ep;
  logic                advance_rr, do_get, gnt_avail, is_last, pop, issue_ok;
  logic [1:0]          fifo_count;
  logic [2:0]          occ;
  logic                fifo_valid;
  logic [FW-1:0]       fifo_head;

`ifdef USB_OUT_ARB_FIXED_PRIO_EN
  assign start_ptr = '0;
`else
  logic [EP_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_rr) rr_ptr_d = next_ep;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign start_ptr = rr_ptr_q;
`endif

  always_comb begin
    gnt_avail = 1'b0;
    for (int e = 0; e < NUM_OUT_EPS; e++)
      if (gnt_ep_q == EP_IDX_W'(e)) gnt_avail = out_ep_data_avail[e];
  end

  assign next_ep = (gnt_ep_q == EP_IDX_W'(NUM_OUT_EPS - 1)) ? '0 : gnt_ep_q + 1'b1;
  assign pop     = fifo_valid & m_ready;
  // Bytes queued plus in flight, after this cycle's pop, must leave a free slot.
  assign occ      = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue_ok = (occ < 3'd2);
  // avail already reflects the advanced read address when the byte lands.
  assign is_last  = inflight_q & ~gnt_avail;

  always_comb begin
    state_d     = state_q;
    gnt_ep_d    = gnt_ep_q;
    inflight_d  = 1'b0;
    pkt_abort_d = 1'b0;
    advance_rr  = 1'b0;
    do_get      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|out_ep_data_avail) begin
          gnt_ep_d = first_set_from(MAX_EPS'(out_ep_data_avail), start_ptr, NUM_OUT_EPS);
          state_d  = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        if (gnt_avail && issue_ok) begin
          do_get     = 1'b1;
          inflight_d = 1'b1;
        end
        if (is_last) begin
          state_d    = ARB_DRAIN;
          advance_rr = 1'b1;
        end else if (!inflight_q && !gnt_avail) begin
          state_d     = ARB_IDLE;
          pkt_abort_d = 1'b1;
          advance_rr  = 1'b1;
        end
      end
      ARB_DRAIN: begin
        if (!inflight_q) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      gnt_ep_q    <= '0;
      inflight_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_ep_q    <= gnt_ep_d;
      inflight_q  <= inflight_d;
      pkt_abort_q <= pkt_abort_d;
    end
  end

  always_comb begin
    out_ep_data_get = '0;
    for (int e = 0; e < NUM_OUT_EPS; e++)
      out_ep_data_get[e] = do_get && !reset && (gnt_ep_q == EP_IDX_W'(e));
  end

  usb_skid_fifo2 #(.WIDTH(FW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   ({out_ep_data, EP_NUM_W'(gnt_ep_q), is_last}),
    .out_valid (fifo_valid),
    .out_ready (m_ready),
    .out_data  (fifo_head),
    .count     (fifo_count)
  );

  assign m_valid   = fifo_valid;
  assign m_data    = fifo_head[FW-1 -: 8];
  assign m_ep      = fifo_head[EP_NUM_W:1];
  assign m_last    = fifo_head[0];
  assign pkt_abort = pkt_abort_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule
